// File: rtl/matrix_feeder_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
//   Shared definitions for the matrix multiplier front end: the feeder FSM
//   state encoding, operand/beat counts and the index widths that the
//   multiplier and the result drain reuse.
//   No ports (package).
// -----------------------------------------------------------------------------
package matrix_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        SEND   = 2'd2
    } feeder_state_t;

    // Default matrix dimension (must be even).
    localparam int MW         = 4;
    localparam int N_ELEM     = MW * MW;
    localparam int N_BEATS    = MW * MW / 2;
    localparam int ELEM_IDX_W = $clog2(2 * N_ELEM);
    localparam int BEAT_IDX_W = $clog2(N_BEATS);

    // Index widths for an arbitrary (even) dimension.
    function automatic int elem_idx_w(input int mw);
        return $clog2(2 * mw * mw);
    endfunction

    function automatic int beat_idx_w(input int mw);
        return (mw * mw / 2 > 1) ? $clog2(mw * mw / 2) : 1;
    endfunction

endpackage

// File: rtl/matrix_feeder_if.sv
// -----------------------------------------------------------------------------
// matrix_feeder_if
//   Groups the feeder's element input stream and its beat output to the
//   multiplier write port.
//
//   Handshake semantics (both channels): a transfer happens on a rising
//   w_clk edge where the source's valid (in_valid / w_en) and the sink's
//   ready (in_ready / w_ready) are both high. Once valid is raised the source
//   holds its data stable until the transfer happens; ready may change freely.
//
//   Modports:
//     master - the feeder: consumes in_*, drives in_ready, wdata, w_en.
//     slave  - the environment: drives in_*, w_ready, observes the rest.
// -----------------------------------------------------------------------------
interface matrix_feeder_if #(
    parameter int WIDTH        = 8,
    parameter int NUM_ELEMENTS = 4
);
    logic [WIDTH-1:0]              in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_last;
    logic [NUM_ELEMENTS*WIDTH-1:0] wdata;
    logic                          w_en;
    logic                          w_ready;

    modport master (
        input  in_data, in_valid, in_last, w_ready,
        output in_ready, wdata, w_en
    );

    modport slave (
        output in_data, in_valid, in_last, w_ready,
        input  in_ready, wdata, w_en
    );
endinterface

// File: rtl/matrix_feeder_beat_mux.sv
// -----------------------------------------------------------------------------
// feeder_beat_mux
//   Combinational selection of the four operand elements that make up one
//   write beat: {A[r][c], A[r+1][c], B[r][c], B[r+1][c]}, A[r][c] in the MSBs.
//   Beats walk the row pairs of a column before moving to the next column.
//
//   Ports:
//     a_flat_i     in  A operand, element k (row-major) at bits [k*WIDTH +: WIDTH]
//     b_flat_i     in  B operand, same layout
//     beat_i       in  beat index
//     beat_data_o  out packed beat
// -----------------------------------------------------------------------------
module feeder_beat_mux #(
    parameter int WIDTH        = 8,
    parameter int MATRIX_WIDTH = 4,
    parameter int NUM_ELEMENTS = 4,
    parameter int BEAT_W       = 3
) (
    input  logic [MATRIX_WIDTH*MATRIX_WIDTH*WIDTH-1:0] a_flat_i,
    input  logic [MATRIX_WIDTH*MATRIX_WIDTH*WIDTH-1:0] b_flat_i,
    input  logic [BEAT_W-1:0]                          beat_i,
    output logic [NUM_ELEMENTS*WIDTH-1:0]              beat_data_o
);
    localparam int PAIRS = MATRIX_WIDTH / 2;

    int col;
    int row;
    int k0;
    int k1;

    always_comb begin
        col = int'(beat_i) / PAIRS;
        row = 2 * (int'(beat_i) % PAIRS);
        k0  = row * MATRIX_WIDTH + col;
        k1  = k0 + MATRIX_WIDTH;      // same column, next row
        beat_data_o = {a_flat_i[k0*WIDTH +: WIDTH], a_flat_i[k1*WIDTH +: WIDTH],
                       b_flat_i[k0*WIDTH +: WIDTH], b_flat_i[k1*WIDTH +: WIDTH]};
    end
endmodule

// File: rtl/matrix_feeder.sv
// -----------------------------------------------------------------------------
// matrix_feeder
//   Upstream loader for the matrix multiplier. Captures a serial stream of
//   A (row-major) then B (row-major), buffers both operands, then issues
//   packed column-pair beats to the multiplier write port.
//
//   Ports:
//     w_clk        in  clock
//     w_reset_n    in  asynchronous active-low reset
//     bus          matrix_feeder_if.master (in_data/in_valid/in_ready/in_last,
//                  wdata/w_en/w_ready)
//     busy         out high in LOAD_B and SEND
//     err          out sticky framing error
//     dbg_state_o  out current FSM state
//
//   Build option: FEEDER_LAST_CHECK_EN enables in_last framing checks; when
//   undefined in_last is ignored and err is tied low.
//
//   All outputs decode from registers only; there is no combinational path
//   from in_valid, in_data or w_ready to any output.
// -----------------------------------------------------------------------------
module matrix_feeder
    import matrix_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int MATRIX_WIDTH = MW,
    parameter int NUM_ELEMENTS = 4
) (
    input  logic            w_clk,
    input  logic            w_reset_n,
    matrix_feeder_if.master bus,
    output logic            busy,
    output logic            err,
    output feeder_state_t   dbg_state_o
);
    localparam int NE = MATRIX_WIDTH * MATRIX_WIDTH;
    localparam int NB = NE / 2;
    localparam int EW = elem_idx_w(MATRIX_WIDTH);
    localparam int BW = beat_idx_w(MATRIX_WIDTH);

    feeder_state_t             state_q, state_d;
    logic [EW-1:0]             elem_cnt_q, elem_cnt_d;
    logic [BW-1:0]             beat_cnt_q, beat_cnt_d;
    logic [NE*WIDTH-1:0]       a_q, a_d;
    logic [NE*WIDTH-1:0]       b_q, b_d;
    logic [NUM_ELEMENTS*WIDTH-1:0] beat_data;

    logic accept;
    logic last_elem;
    logic last_beat;

    assign accept    = bus.in_valid && (state_q != SEND);
    assign last_elem = (elem_cnt_q == EW'(NE - 1));
    assign last_beat = (beat_cnt_q == BW'(NB - 1));

`ifdef FEEDER_LAST_CHECK_EN
    logic err_q, err_d;
    logic frame_end;
    assign frame_end = (state_q == LOAD_B) && last_elem;
`endif

    // -------------------------------------------------------------------------
    // State, counters and operand storage
    // -------------------------------------------------------------------------
    always_ff @(posedge w_clk or negedge w_reset_n) begin
        if (!w_reset_n) begin
            state_q    <= LOAD_A;
            elem_cnt_q <= '0;
            beat_cnt_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
`ifdef FEEDER_LAST_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            elem_cnt_q <= elem_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
`ifdef FEEDER_LAST_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        elem_cnt_d = elem_cnt_q;
        beat_cnt_d = beat_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
`ifdef FEEDER_LAST_CHECK_EN
        err_d      = err_q;
`endif
        case (state_q)
            LOAD_A: begin
                if (accept) begin
                    a_d[int'(elem_cnt_q)*WIDTH +: WIDTH] = bus.in_data;
                    if (last_elem) begin
                        state_d    = LOAD_B;
                        elem_cnt_d = '0;
                    end else begin
                        elem_cnt_d = elem_cnt_q + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    b_d[int'(elem_cnt_q)*WIDTH +: WIDTH] = bus.in_data;
                    if (last_elem) begin
                        state_d    = SEND;
                        elem_cnt_d = '0;
                    end else begin
                        elem_cnt_d = elem_cnt_q + 1'b1;
                    end
                end
            end
            SEND: begin
                if (bus.w_ready) begin
                    if (last_beat) begin
                        state_d    = LOAD_A;
                        beat_cnt_d = '0;
                        elem_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = LOAD_A;
                elem_cnt_d = '0;
                beat_cnt_d = '0;
            end
        endcase

`ifdef FEEDER_LAST_CHECK_EN
        // An early frame marker abandons the partial load; a missing marker
        // on the final element is flagged but the pair is still sent.
        if (accept) begin
            if (bus.in_last && !frame_end) begin
                err_d      = 1'b1;
                state_d    = LOAD_A;
                elem_cnt_d = '0;
            end else if (!bus.in_last && frame_end) begin
                err_d = 1'b1;
            end
        end
`endif
    end

    feeder_beat_mux #(
        .WIDTH       (WIDTH),
        .MATRIX_WIDTH(MATRIX_WIDTH),
        .NUM_ELEMENTS(NUM_ELEMENTS),
        .BEAT_W      (BW)
    ) u_beat_mux (
        .a_flat_i   (a_q),
        .b_flat_i   (b_q),
        .beat_i     (beat_cnt_q),
        .beat_data_o(beat_data)
    );

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.in_ready = (state_q != SEND);
    assign bus.w_en     = (state_q == SEND);
    assign bus.wdata    = (state_q == SEND) ? beat_data : '0;
    assign busy         = (state_q != LOAD_A);
    assign dbg_state_o  = state_q;

`ifdef FEEDER_LAST_CHECK_EN
    assign err = err_q;
`else
    logic unused_in_last;
    assign unused_in_last = bus.in_last;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_feeder.sv
// -----------------------------------------------------------------------------
// tb_matrix_feeder
//   Self-checking bench for matrix_feeder. Operands are kept as 4x4 arrays;
//   the expected beat sequence is derived from them and queued in exp_q.
// -----------------------------------------------------------------------------
module tb_matrix_feeder;
    import matrix_pkg::*;

    localparam int W = 8;

    logic          clk;
    logic          rst_n;
    logic          busy;
    logic          err;
    feeder_state_t dbg_state;

    matrix_feeder_if #(.WIDTH(W), .NUM_ELEMENTS(4)) bus ();

    matrix_feeder #(
        .WIDTH       (W),
        .MATRIX_WIDTH(4),
        .NUM_ELEMENTS(4)
    ) dut (
        .w_clk      (clk),
        .w_reset_n  (rst_n),
        .bus        (bus),
        .busy       (busy),
        .err        (err),
        .dbg_state_o(dbg_state)
    );

    // -------------------------------------------------------------------------
    // Clock
    // -------------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  fa[16];        // A stream, row-major
    logic [7:0]  fb[16];        // B stream, row-major
    logic [7:0]  ma[4][4];
    logic [7:0]  mb[4][4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic frame_pattern();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                fa[4*i+j] = 8'(4*i + j + 1);
                fb[4*i+j] = 8'(8'h10 + 4*i + j);
            end
    endtask

    task automatic frame_random();
        for (int k = 0; k < 16; k++) begin
            fa[k] = 8'($urandom_range(0, 255));
            fb[k] = 8'($urandom_range(0, 255));
        end
    endtask

    // Reference: beats visit rows {0,1} then {2,3} of each column in turn.
    task automatic build_expected();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = fa[4*i+j];
                mb[i][j] = fb[4*i+j];
            end
        exp_q.delete();
        for (int col = 0; col < 4; col++)
            for (int rp = 0; rp < 4; rp += 2)
                exp_q.push_back({ma[rp][col], ma[rp+1][col], mb[rp][col], mb[rp+1][col]});
    endtask

    // Drive stream elements [first, first+count). Called and returns at a
    // negedge. gap=1 inserts an idle cycle before each element. in_last is
    // raised on element 31, or on bad_last when bad_last >= 0.
    task automatic load_elems(input int first, input int count, input int gap, input int bad_last);
        for (int k = first; k < first + count; k++) begin
            if (gap != 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom_range(0, 255));
                bus.in_last  = 1'b0;
                @(negedge clk);
            end
            if (k == 31) check("w_en_before_last_elem", {31'd0, bus.w_en}, 32'd0);
            bus.in_valid = 1'b1;
            bus.in_data  = (k < 16) ? fa[k] : fb[k-16];
            bus.in_last  = (bad_last >= 0) ? (k == bad_last) : (k == 31);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Consume beats until stop_after have been accepted. Starts at the negedge
    // where SEND is expected. Optionally stalls at one beat and drives
    // in_valid during SEND.
    task automatic drain(input int stall_beat, input int stall_len, input int spam, input int stop_after);
        int beat  = 0;
        int stall = 0;
        while (beat < stop_after) begin
            check("w_en_send", {31'd0, bus.w_en}, 32'd1);
            check("busy_send", {31'd0, busy}, 32'd1);
            check($sformatf("wdata_beat%0d", beat), bus.wdata, exp_q[0]);
            if (spam != 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'($urandom_range(0, 255));
                check("in_ready_send", {31'd0, bus.in_ready}, 32'd0);
            end
            if (beat == stall_beat && stall < stall_len) begin
                bus.w_ready = 1'b0;
                stall++;
            end else begin
                bus.w_ready = 1'b1;
                void'(exp_q.pop_front());
                beat++;
            end
            @(negedge clk);
        end
        bus.w_ready  = 1'b1;
        bus.in_valid = 1'b0;
        if (stop_after == 8) begin
            check("in_ready_after_beat7", {31'd0, bus.in_ready}, 32'd1);
            check("w_en_after_beat7", {31'd0, bus.w_en}, 32'd0);
            check("wdata_after_beat7", bus.wdata, 32'd0);
            check("busy_after_beat7", {31'd0, busy}, 32'd0);
        end
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        rst_n        = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.w_ready  = 1'b1;
        #1;
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reset_w_en", {31'd0, bus.w_en}, 32'd0);
        check("reset_wdata", bus.wdata, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, {30'd0, LOAD_A});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: known pattern, back-to-back beats
        frame_pattern();
        build_expected();
        load_elems(0, 32, 0, -1);
        check("beat0_pattern", bus.wdata, 32'h01051014);
        drain(-1, 0, 0, 8);

        // 2: same data, multiplier stalls 5 cycles at beat 3
        frame_pattern();
        build_expected();
        load_elems(0, 32, 0, -1);
        drain(3, 5, 0, 8);

        // 3: gapped load, in_valid driven during SEND must be ignored
        frame_random();
        build_expected();
        load_elems(0, 32, 1, -1);
        drain(-1, 0, 1, 8);

        // 4: reset mid-SEND at beat 4, then a fresh pair
        frame_random();
        build_expected();
        load_elems(0, 32, 0, -1);
        drain(-1, 0, 0, 4);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_w_en", {31'd0, bus.w_en}, 32'd0);
        check("rst_mid_wdata", bus.wdata, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame_random();
        build_expected();
        load_elems(0, 32, 0, -1);
        drain(-1, 0, 0, 8);

        // 5: early frame marker at element 20
        frame_random();
        load_elems(0, 21, 0, 20);
`ifdef FEEDER_LAST_CHECK_EN
        check("last_err_set", {31'd0, err}, 32'd1);
        check("last_state_load_a", {30'd0, dbg_state}, {30'd0, LOAD_A});
        frame_random();
        build_expected();
        load_elems(0, 32, 0, -1);
        drain(-1, 0, 0, 8);
        check("last_err_sticky", {31'd0, err}, 32'd1);
`else
        check("last_err_ignored", {31'd0, err}, 32'd0);
        check("last_state_load_b", {30'd0, dbg_state}, {30'd0, LOAD_B});
        build_expected();
        load_elems(21, 11, 0, -1);
        drain(-1, 0, 0, 8);
        check("last_err_still_0", {31'd0, err}, 32'd0);
`endif

        // 6: two pairs back-to-back; second load starts right after beat 7
        frame_random();
        build_expected();
        load_elems(0, 32, 0, -1);
        drain(-1, 0, 0, 8);
        frame_random();
        build_expected();
        load_elems(0, 32, 0, -1);
        drain(-1, 0, 0, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
